// File: rtl/io_unit_mmio.sv
// MMIO unit: LEDs, switch/button hex entry, committed-word FIFO,
// display handshake and a free-running prescaled counter.
module io_unit_mmio #(
  parameter int DATA_WIDTH = 32,
  parameter int LED_WIDTH  = 16,
  parameter int SW_WIDTH   = 16,
  parameter int NDIGITS    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_DIV    = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             io_addr,
  input  logic [DATA_WIDTH-1:0]  io_dout,
  output logic [DATA_WIDTH-1:0]  io_din,
  input  logic                   io_we,
  input  logic                   io_rd,
  output logic [LED_WIDTH-1:0]   led,
  input  logic [SW_WIDTH-1:0]    sw,
  input  logic                   btnr,
  input  logic                   btnc,
  output logic [4*NDIGITS-1:0]   disp_data
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = 4 * NDIGITS;
  localparam int IW = SW_WIDTH + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

  localparam logic [7:0] A_LED = 8'h00;
  localparam logic [7:0] A_SWT = 8'h04;
  localparam logic [7:0] A_RDY = 8'h08;
  localparam logic [7:0] A_SEG = 8'h0C;
  localparam logic [7:0] A_VLD = 8'h10;
  localparam logic [7:0] A_SWX = 8'h14;
  localparam logic [7:0] A_CNT = 8'h18;
  localparam logic [7:0] A_STS = 8'h1C;

  logic [IW-1:0]       s1, s2, s3, pls;
  logic [SW_WIDTH-1:0] sw_p;
  logic [3:0]          h;
  logic                p, ev_bs, ev_cm;

  logic [DW-1:0]       led_data;
  logic [TW-1:0]       tmp;
  logic [TW-1:0]       seg_data;
  logic                seg_rdy;
  logic                ovf;

  logic [TW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wp, rp;
  logic [CW-1:0]       fcnt;
  logic                empty, full;
  logic                pop, push, set_ovf;

  logic [DW-1:0]       cnt_data;
  logic [PW-1:0]       pre;

  logic wr_led, wr_seg, wr_cnt, wr_sts;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {btnr, btnc, sw};
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pls  = s2 & ~s3;
  assign sw_p = pls[SW_WIDTH-1:0];
  assign p    = |sw_p;

  // Mutually exclusive events after p > btnr > btnc priority
  assign ev_bs = pls[IW-1] & ~p;
  assign ev_cm = pls[IW-2] & ~p & ~pls[IW-1];

  always_comb begin
    h = '0;
    for (int i = SW_WIDTH - 1; i >= 0; i--) begin
      if (sw_p[i]) h = 4'(i);
    end
  end

  assign wr_led = io_we && (io_addr == A_LED);
  assign wr_seg = io_we && (io_addr == A_SEG);
  assign wr_cnt = io_we && (io_addr == A_CNT);
  assign wr_sts = io_we && (io_addr == A_STS);

  assign empty   = (fcnt == '0);
  assign full    = (fcnt == CW'(FIFO_DEPTH));
  assign pop     = io_rd && (io_addr == A_SWX) && !empty;
  assign push    = ev_cm && (!full || pop);
  assign set_ovf = ev_cm && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= tmp;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      fcnt <= fcnt + CW'(1);
      else if (pop && !push) fcnt <= fcnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmp <= '0;
    end else begin
      unique case (1'b1)
        p:     tmp <= (tmp << 4) | TW'(h);
        ev_bs: tmp <= tmp >> 4;
        push:  tmp <= '0;
        default: ;
      endcase
    end
  end

  // A new overflow in the same cycle as a clear stays visible
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (set_ovf) begin
      ovf <= 1'b1;
    end else if (wr_sts && io_dout[0]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_rdy  <= 1'b1;
      seg_data <= '0;
    end else if (wr_seg) begin
      seg_rdy  <= 1'b0;
      seg_data <= io_dout[TW-1:0];
    end else if (p || ev_bs || ev_cm) begin
      seg_rdy  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_data <= '0;
    end else if (wr_led) begin
      led_data <= io_dout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_data <= '0;
      pre      <= '0;
    end else if (wr_cnt) begin
      cnt_data <= io_dout;
      pre      <= '0;
    end else if (pre == PW'(CNT_DIV - 1)) begin
      cnt_data <= cnt_data + DW'(1);
      pre      <= '0;
    end else begin
      pre      <= pre + PW'(1);
    end
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      A_LED: io_din = led_data;
      A_SWT: io_din = DW'(s2);
      A_RDY: io_din = DW'(seg_rdy);
      A_VLD: io_din = DW'(!empty);
      A_SWX: if (!empty) io_din = DW'(mem[rp]);
      A_CNT: io_din = cnt_data;
      A_STS: io_din = DW'({8'(fcnt), 6'h0, full, ovf});
      default: ;
    endcase
  end

  assign led       = led_data[LED_WIDTH-1:0];
  assign disp_data = seg_rdy ? tmp : seg_data;

endmodule
